// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared width, NOP encoding and fetch FSM state encodings
package if_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {FS_IDLE = 2'd0, FS_WAIT = 2'd1, FS_DROP = 2'd2} fs_e;
endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// fetch_skid_buf: one-entry {valid, inst, pc} holding register; flush beats load beats unload
module fetch_skid_buf
  import if_fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o
);
  logic            valid_q, valid_d;
  logic [XLEN-1:0] inst_q, inst_d, pc_q, pc_d;
  // next entry: flush drops it, load captures a new payload, unload empties it
  always_comb begin
    valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : unload_i ? 1'b0 : valid_q;
    inst_d  = load_i ? inst_i : inst_q;
    pc_d    = load_i ? pc_i : pc_q;
  end
  // entry register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end
  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC-driven req/ack instruction fetch with skid to ID; FETCH_PERF_EN builds perf counters
module if_fetch_unit
  import if_fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect,
  output logic            fetch_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_stall,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stalls,
  output logic [31:0]     perf_dropped
);
  fs_e             state_q, state_d;
  logic            req_q, req_d, valid_q, valid_d;
  logic [XLEN-1:0] addr_q, addr_d, inst_q, inst_d, ipc_q, ipc_d;
  logic            skid_valid;
  logic [XLEN-1:0] skid_inst, skid_pc;
  logic            accept, discard, out_en, to_out, skid_load, skid_unload;

  assign accept      = state_q == FS_WAIT && imem_ack && !redirect;
  assign discard     = imem_ack && (state_q == FS_DROP || (state_q == FS_WAIT && redirect));
  assign out_en      = !valid_q || !id_stall;
  assign to_out      = accept && out_en;
  assign skid_load   = accept && !out_en;
  assign skid_unload = out_en && skid_valid;
  assign fetch_stall = !accept && !redirect;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .unload_i(skid_unload),
    .flush_i (redirect),
    .inst_i  (imem_rdata),
    .pc_i    (addr_q),
    .valid_o (skid_valid),
    .inst_o  (skid_inst),
    .pc_o    (skid_pc)
  );

  // request FSM: a request is never withdrawn, so a redirect while waiting parks in DROP
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      FS_IDLE: if (!redirect && !skid_valid) begin
        state_d = FS_WAIT;
        req_d   = 1'b1;
        addr_d  = pc_i;
      end
      FS_WAIT: begin
        if (to_out) addr_d = pc_i + XLEN'(4);
        else if (imem_ack) begin
          state_d = FS_IDLE;
          req_d   = 1'b0;
        end else if (redirect) state_d = FS_DROP;
      end
      FS_DROP: if (imem_ack) begin
        state_d = FS_IDLE;
        req_d   = 1'b0;
      end
      default: begin
        state_d = FS_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // ID output register: redirect flushes, skid drains before a fresh response
  always_comb begin
    valid_d = redirect ? 1'b0 : out_en ? (skid_valid || to_out) : valid_q;
    inst_d  = skid_unload ? skid_inst : to_out ? imem_rdata : inst_q;
    ipc_d   = skid_unload ? skid_pc : to_out ? addr_q : ipc_q;
  end

  // state, request and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst       = valid_q ? inst_q : NOP_INST;
  assign inst_pc    = ipc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, stalls_q, dropped_q;
  // wrapping event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      stalls_q  <= '0;
      dropped_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(accept);
      stalls_q  <= stalls_q + 32'(fetch_stall);
      dropped_q <= dropped_q + 32'(discard);
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
  assign perf_dropped = dropped_q;
`else
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
  assign perf_dropped = '0;
  logic unused_discard;
  assign unused_discard = discard;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: vector table, corner sequences and randomized run against a stream-level model
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] pc_i = '0, imem_addr, imem_rdata = '0, inst, inst_pc;
  logic redirect = 1'b0, fetch_stall, imem_req, imem_ack = 1'b0, id_stall = 1'b0, inst_valid;
  logic [31:0] perf_fetched, perf_stalls, perf_dropped;
  int n_pass = 0, n_tot = 0;
  logic fst_s;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .redirect(redirect), .fetch_stall(fetch_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .perf_fetched(perf_fetched), .perf_stalls(perf_stalls), .perf_dropped(perf_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic redir, ack, idst;
    logic [31:0] rdata;
    logic e_fst, e_req;
    logic [31:0] e_addr;
    logic e_val;
    logic [31:0] e_ipc, e_inst;
  } vec_t;
  vec_t tbl [18];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc(input logic [31:0] pc, input logic r, input logic a, input logic s, input logic [31:0] d);
    @(negedge clk);
    pc_i = pc; redirect = r; imem_ack = a; id_stall = s; imem_rdata = d;
    #1 fst_s = fetch_stall;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] D0 = 32'h0050_0093, D4 = 32'h00A0_0113, D8 = 32'h00F0_0193,
                          DC = 32'h0140_0213, DX = 32'h0FF0_0293, DZ = 32'hDEAD_BEEF, DH = 32'h0190_0313;

  logic pend, taint, prev_req, acc;
  int cnt, n_cons, e_fet, e_stl, e_drp;
  logic [31:0] pc, exp_pc, pend_addr, tgt;

  initial begin
    tbl[0]  = '{32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, NOP};
    tbl[1]  = '{32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, NOP};
    tbl[2]  = '{32'h0, 1'b0, 1'b1, 1'b0, D0, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0, D0};
    tbl[3]  = '{32'h4, 1'b0, 1'b1, 1'b0, D4, 1'b0, 1'b1, 32'h8, 1'b1, 32'h4, D4};
    tbl[4]  = '{32'h8, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4, D4};
    tbl[5]  = '{32'h8, 1'b0, 1'b1, 1'b1, D8, 1'b0, 1'b0, 32'h8, 1'b1, 32'h4, D4};
    tbl[6]  = '{32'hC, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h8, 1'b1, 32'h4, D4};
    tbl[7]  = '{32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 1'b1, 32'h8, D8};
    tbl[8]  = '{32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b0, 32'h0, NOP};
    tbl[9]  = '{32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b0, 32'h0, NOP};
    tbl[10] = '{32'hC, 1'b0, 1'b1, 1'b0, DC, 1'b0, 1'b1, 32'h10, 1'b1, 32'hC, DC};
    tbl[11] = '{32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, NOP};
    tbl[12] = '{32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, DZ, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0, NOP};
    tbl[13] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP};
    tbl[14] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP};
    tbl[15] = '{32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, DX, 1'b0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, DX};
    tbl[16] = '{32'h0, 1'b1, 1'b1, 1'b0, DZ, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP};
    tbl[17] = '{32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, NOP};

    repeat (2) @(negedge clk);
    chk("rst.req", 32'(imem_req), 32'd0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.valid", 32'(inst_valid), 32'd0);
    chk("rst.inst", inst, NOP);
    chk("rst.ipc", inst_pc, 32'h0);
    chk("rst.perf", perf_fetched | perf_stalls | perf_dropped, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].pc, tbl[i].redir, tbl[i].ack, tbl[i].idst, tbl[i].rdata);
      chk($sformatf("v%0d.fstall", i), 32'(fst_s), 32'(tbl[i].e_fst));
      chk($sformatf("v%0d.req", i), 32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("v%0d.addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d.valid", i), 32'(inst_valid), 32'(tbl[i].e_val));
      chk($sformatf("v%0d.inst", i), inst, tbl[i].e_inst);
      if (tbl[i].e_val) chk($sformatf("v%0d.ipc", i), inst_pc, tbl[i].e_ipc);
    end

    // finish fetch of 0x100, then async reset mid-WAIT
    cyc(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(32'h100, 1'b0, 1'b1, 1'b0, DH);
    chk("h100.inst", inst, DH);
    chk("h100.addr", imem_addr, 32'h104);
    @(negedge clk);
    imem_ack = 1'b0; pc_i = 32'h104;
    #2 rst = 1'b1;
    #1;
    chk("arst.req", 32'(imem_req), 32'd0);
    chk("arst.addr", imem_addr, 32'h0);
    chk("arst.valid", 32'(inst_valid), 32'd0);
    chk("arst.inst", inst, NOP);
    chk("arst.ipc", inst_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0; pc_i = 32'h200; imem_ack = 1'b1; imem_rdata = DZ;
    @(posedge clk);
    #1;
    chk("stale.valid", 32'(inst_valid), 32'd0);
    chk("stale.req", 32'(imem_req), 32'd1);
    chk("stale.addr", imem_addr, 32'h200);
    cyc(32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("stale.valid2", 32'(inst_valid), 32'd0);

    // redirect in WAIT, memory answers three cycles later
    cyc(32'h200, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("drop.fstall", 32'(fst_s), 32'd0);
    chk("drop.req", 32'(imem_req), 32'd1);
    cyc(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drop.fstall2", 32'(fst_s), 32'd1);
    cyc(32'h100, 1'b0, 1'b1, 1'b0, DZ);
    chk("drop.ack.req", 32'(imem_req), 32'd0);
    chk("drop.ack.valid", 32'(inst_valid), 32'd0);
    cyc(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drop.next.addr", imem_addr, 32'h100);
    chk("drop.next.req", 32'(imem_req), 32'd1);
`ifdef FETCH_PERF_EN
    chk("drop.perf_dropped", perf_dropped, 32'd1);
    chk("drop.perf_stalls", perf_stalls, 32'd6);
    chk("drop.perf_fetched", perf_fetched, 32'd0);
`else
    chk("drop.perf_tied", perf_dropped | perf_stalls | perf_fetched, 32'h0);
`endif

    // randomized run: TB acts as PC register and memory, checks the delivered stream
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pc = 32'h1000; exp_pc = pc; pend = 1'b0; taint = 1'b0; prev_req = 1'b0; cnt = 0;
    n_cons = 0; e_fet = 0; e_stl = 0; e_drp = 0; pend_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (imem_ack) pend = 1'b0;
      imem_ack = 1'b0;
      if (pend) chk("proto.hold", {imem_req, imem_addr[30:0]}, {1'b1, pend_addr[30:0]});
      if (imem_req && !pend) begin
        pend = 1'b1; taint = 1'b0; pend_addr = imem_addr;
        cnt = int'($urandom_range(1, 3)) + (prev_req ? 0 : 1);
        chk("issue.addr", imem_addr, pc);
      end
      if (pend) begin
        if (cnt <= 1) begin
          imem_ack = 1'b1;
          imem_rdata = memf(imem_addr);
        end else cnt--;
      end
      pc_i = pc;
      id_stall = $urandom_range(0, 3) == 0;
      redirect = $urandom_range(0, 11) == 0;
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      #1;
      if (redirect && pend) taint = 1'b1;
      acc = imem_ack && !taint;
      chk("rnd.fstall", 32'(fetch_stall), 32'(!acc && !redirect));
      if (!inst_valid) chk("rnd.nop", inst, NOP);
      if (acc) e_fet++;
      if (imem_ack && taint) e_drp++;
      if (!acc && !redirect) e_stl++;
      if (inst_valid && !id_stall && !redirect) begin
        chk("rnd.ipc", inst_pc, exp_pc);
        chk("rnd.inst", inst, memf(exp_pc));
        exp_pc += 32'd4;
        n_cons++;
      end
      if (redirect) begin
        exp_pc = tgt;
        pc = tgt;
      end else if (acc) pc += 32'd4;
      prev_req = imem_req;
      @(negedge clk);
    end
    chk("rnd.progress", 32'(n_cons > 300), 32'd1);
`ifdef FETCH_PERF_EN
    chk("rnd.perf_fetched", perf_fetched, 32'(e_fet));
    chk("rnd.perf_stalls", perf_stalls, 32'(e_stl));
    chk("rnd.perf_dropped", perf_dropped, 32'(e_drp));
`else
    chk("rnd.perf_tied", perf_dropped | perf_stalls | perf_fetched, 32'h0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
